// File: rtl/mem_test.sv
// mem_test: cache exercise harness with an 8x8 backing RAM, a 4-line
// fully-associative write-through / write-allocate cache with true LRU,
// and a sequencer FSM walking a fixed address pattern.
module mem_test (
    input  logic       clk,
    input  logic       clr,
    input  logic       rw,
    input  logic       enab,
    output logic [7:0] data_out,
    output logic       hit,
    output logic [7:0] addr0,
    output logic [7:0] addr1,
    output logic [7:0] addr2,
    output logic [7:0] addr3,
    output logic [7:0] data0,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [7:0] data3,
    output logic [7:0] ram0,
    output logic [7:0] ram1,
    output logic [7:0] ram2,
    output logic [7:0] ram3,
    output logic [7:0] ram4,
    output logic [7:0] ram5,
    output logic [7:0] ram6,
    output logic [7:0] ram7,
    output logic [3:0] state,
    output logic [7:0] cache_addr,
    output logic [7:0] cache_data,
    output logic [2:0] i_out,
    output logic       cache_clr,
    output logic       cache_enab,
    output logic       cache_rw,
    output logic [1:0] cache_hit,
    output logic [1:0] cache_lru
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_IDLE   = 4'd1,
        S_LOOKUP = 4'd2,
        S_FETCH  = 4'd3,
        S_WRITE  = 4'd4,
        S_DONE   = 4'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_seq;
    logic        r_op;
    logic [7:0]  r_data_out;
    logic        r_hit;
    logic [1:0]  r_cache_hit;
    logic [1:0]  r_acc;
    logic [7:0]  r_cache_addr;
    logic [7:0]  r_cache_data;
    logic [7:0]  r_tag   [4];
    logic [7:0]  r_data  [4];
    logic        r_valid [4];
    logic [1:0]  r_age   [4];
    logic [7:0]  r_ram   [8];

    logic [2:0]  w_i;
    logic        w_hit;
    logic [1:0]  w_hit_idx;
    logic [1:0]  w_lru;

    assign w_i = {r_seq[3], r_seq[1:0]};

    // Tag match across valid lines; lowest matching index wins
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_hit && r_valid[i] && (r_tag[i] == r_cache_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = 2'(i);
            end
        end
    end

    // LRU line is the one whose age has reached 3
    always_comb begin
        w_lru = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_age[i] == 2'd3) begin
                w_lru = 2'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_IDLE;
            S_IDLE:   w_next = enab ? S_LOOKUP : S_IDLE;
            S_LOOKUP: begin
                if (r_op)       w_next = S_WRITE;
                else if (w_hit) w_next = S_DONE;
                else            w_next = S_FETCH;
            end
            S_FETCH:  w_next = S_DONE;
            S_WRITE:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_RESET;
        endcase
    end

    // Datapath: cache lines, RAM, LRU ages and sequencer, updated per state.
    // r_acc captures the target line in LOOKUP (hit line, else LRU line) so
    // FETCH/WRITE and the DONE age update all act on the same line.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_seq        <= '0;
            r_op         <= 1'b0;
            r_data_out   <= '0;
            r_hit        <= 1'b0;
            r_cache_hit  <= '0;
            r_acc        <= '0;
            r_cache_addr <= '0;
            r_cache_data <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
                r_valid[i] <= 1'b0;
                r_age[i]   <= 2'(3 - i);
            end
            for (int unsigned k = 0; k < 8; k++) begin
                r_ram[k] <= 8'hA0 + 8'(k);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enab) begin
                        r_op         <= rw;
                        r_cache_addr <= {5'b0, w_i};
                        r_cache_data <= 8'h50 + {5'b0, w_i};
                    end
                end
                S_LOOKUP: begin
                    r_hit <= w_hit;
                    r_acc <= w_hit ? w_hit_idx : w_lru;
                    if (w_hit) begin
                        r_cache_hit <= w_hit_idx;
                    end
                    if (!r_op && w_hit) begin
                        r_data_out <= r_data[w_hit_idx];
                    end
                end
                S_FETCH: begin
                    r_tag[r_acc]   <= r_cache_addr;
                    r_data[r_acc]  <= r_ram[w_i];
                    r_valid[r_acc] <= 1'b1;
                    r_data_out     <= r_ram[w_i];
                end
                S_WRITE: begin
                    r_ram[w_i]     <= r_cache_data;
                    r_tag[r_acc]   <= r_cache_addr;
                    r_data[r_acc]  <= r_cache_data;
                    r_valid[r_acc] <= 1'b1;
                    r_data_out     <= r_cache_data;
                end
                S_DONE: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (2'(i) == r_acc) begin
                            r_age[i] <= '0;
                        end else if (r_age[i] < r_age[r_acc]) begin
                            r_age[i] <= r_age[i] + 2'd1;
                        end
                    end
                    r_seq <= r_seq + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign data_out   = r_data_out;
    assign hit        = r_hit;
    assign cache_hit  = r_cache_hit;
    assign cache_lru  = w_lru;
    assign cache_addr = r_cache_addr;
    assign cache_data = r_cache_data;
    assign i_out      = w_i;
    assign cache_clr  = (r_state == S_RESET);
    assign cache_enab = (r_state == S_LOOKUP) || (r_state == S_FETCH) || (r_state == S_WRITE);
    assign cache_rw   = cache_enab & r_op;

    assign addr0 = r_tag[0];
    assign addr1 = r_tag[1];
    assign addr2 = r_tag[2];
    assign addr3 = r_tag[3];
    assign data0 = r_data[0];
    assign data1 = r_data[1];
    assign data2 = r_data[2];
    assign data3 = r_data[3];
    assign ram0  = r_ram[0];
    assign ram1  = r_ram[1];
    assign ram2  = r_ram[2];
    assign ram3  = r_ram[3];
    assign ram4  = r_ram[4];
    assign ram5  = r_ram[5];
    assign ram6  = r_ram[6];
    assign ram7  = r_ram[7];

endmodule

// File: tb/tb_mem_test.sv
// tb_mem_test: directed bench for mem_test with hand-computed expectations.
module tb_mem_test;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rw = 1'b0;
    logic       enab = 1'b0;
    logic [7:0] data_out;
    logic       hit;
    logic [7:0] addr0, addr1, addr2, addr3;
    logic [7:0] data0, data1, data2, data3;
    logic [7:0] ram0, ram1, ram2, ram3, ram4, ram5, ram6, ram7;
    logic [3:0] state;
    logic [7:0] cache_addr, cache_data;
    logic [2:0] i_out;
    logic       cache_clr, cache_enab, cache_rw;
    logic [1:0] cache_hit, cache_lru;

    logic [7:0] t_addr [4];
    logic [7:0] t_data [4];
    logic [7:0] t_ram  [8];

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    mem_test dut (
        .clk(clk), .clr(clr), .rw(rw), .enab(enab),
        .data_out(data_out), .hit(hit),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .ram0(ram0), .ram1(ram1), .ram2(ram2), .ram3(ram3),
        .ram4(ram4), .ram5(ram5), .ram6(ram6), .ram7(ram7),
        .state(state), .cache_addr(cache_addr), .cache_data(cache_data),
        .i_out(i_out), .cache_clr(cache_clr), .cache_enab(cache_enab),
        .cache_rw(cache_rw), .cache_hit(cache_hit), .cache_lru(cache_lru)
    );

    assign t_addr[0] = addr0;
    assign t_addr[1] = addr1;
    assign t_addr[2] = addr2;
    assign t_addr[3] = addr3;
    assign t_data[0] = data0;
    assign t_data[1] = data1;
    assign t_data[2] = data2;
    assign t_data[3] = data3;
    assign t_ram[0]  = ram0;
    assign t_ram[1]  = ram1;
    assign t_ram[2]  = ram2;
    assign t_ram[3]  = ram3;
    assign t_ram[4]  = ram4;
    assign t_ram[5]  = ram5;
    assign t_ram[6]  = ram6;
    assign t_ram[7]  = ram7;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Start one operation from IDLE and return edges until IDLE is reached
    // again. With flip set, rw is inverted once the FSM has left IDLE.
    task automatic run_op(input logic op_rw, input bit flip, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (state != 4'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("idle_timeout", {28'd0, state}, 32'd1);
        rw   = op_rw;
        enab = 1'b1;
        @(posedge clk);
        #1;
        enab = 1'b0;
        if (flip) begin
            check("cache_rw_latched", {31'd0, cache_rw}, {31'd0, op_rw});
            rw = ~op_rw;
        end
        lat = 1;
        while (state != 4'd1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rw = op_rw;
    endtask

    initial begin
        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_cache_clr", {31'd0, cache_clr}, 32'd1);
        check("rst_lru", {30'd0, cache_lru}, 32'd0);
        check("rst_i_out", {29'd0, i_out}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        for (int k = 0; k < 8; k++)
            check($sformatf("rst_ram%0d", k), {24'd0, t_ram[k]}, 32'hA0 + k);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_addr%0d", k), {24'd0, t_addr[k]}, 32'd0);
            check($sformatf("rst_data%0d", k), {24'd0, t_data[k]}, 32'd0);
        end
        @(negedge clk);
        clr = 1'b0;

        // Cold reads 0..3; first one flips rw during LOOKUP
        for (int k = 0; k < 4; k++) begin
            run_op(1'b0, k == 0, cyc);
            check($sformatf("cold_lat%0d", k), cyc, 32'd4);
            check($sformatf("cold_hit%0d", k), {31'd0, hit}, 32'd0);
            check($sformatf("cold_dout%0d", k), {24'd0, data_out}, 32'hA0 + k);
            check($sformatf("cold_addr%0d", k), {24'd0, t_addr[k]}, k);
            check($sformatf("cold_data%0d", k), {24'd0, t_data[k]}, 32'hA0 + k);
            check($sformatf("cold_lru%0d", k), {30'd0, cache_lru}, (k + 1) % 4);
        end
        check("flip_ram0", {24'd0, ram0}, 32'hA0);

        // Warm reads 0..3
        for (int k = 0; k < 4; k++) begin
            run_op(1'b0, 1'b0, cyc);
            check($sformatf("warm_lat%0d", k), cyc, 32'd3);
            check($sformatf("warm_hit%0d", k), {31'd0, hit}, 32'd1);
            check($sformatf("warm_chit%0d", k), {30'd0, cache_hit}, k);
            check($sformatf("warm_dout%0d", k), {24'd0, data_out}, 32'hA0 + k);
        end
        for (int k = 0; k < 8; k++)
            check($sformatf("warm_ram%0d", k), {24'd0, t_ram[k]}, 32'hA0 + k);

        // Eviction with addresses 4..7
        for (int k = 0; k < 4; k++) begin
            run_op(1'b0, 1'b0, cyc);
            check($sformatf("evict_lat%0d", k), cyc, 32'd4);
            check($sformatf("evict_hit%0d", k), {31'd0, hit}, 32'd0);
            check($sformatf("evict_dout%0d", k), {24'd0, data_out}, 32'hA4 + k);
            check($sformatf("evict_addr%0d", k), {24'd0, t_addr[k]}, 32'd4 + k);
            check($sformatf("evict_data%0d", k), {24'd0, t_data[k]}, 32'hA4 + k);
        end

        // enab low in IDLE: everything holds
        @(negedge clk);
        enab = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_state", {28'd0, state}, 32'd1);
        check("hold_dout", {24'd0, data_out}, 32'hA7);
        check("hold_i_out", {29'd0, i_out}, 32'd4);
        check("hold_addr3", {24'd0, addr3}, 32'd7);
        check("hold_lru", {30'd0, cache_lru}, 32'd0);
        check("hold_enab", {31'd0, cache_enab}, 32'd0);

        // Writes from a fresh reset
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_op(1'b1, 1'b0, cyc);
            check($sformatf("wr_lat%0d", k), cyc, 32'd4);
            check($sformatf("wr_hit%0d", k), {31'd0, hit}, 32'd0);
            check($sformatf("wr_ram%0d", k), {24'd0, t_ram[k]}, 32'h50 + k);
            check($sformatf("wr_data%0d", k), {24'd0, t_data[k]}, 32'h50 + k);
            check($sformatf("wr_addr%0d", k), {24'd0, t_addr[k]}, k);
            check($sformatf("wr_dout%0d", k), {24'd0, data_out}, 32'h50 + k);
        end
        check("wr_ram4", {24'd0, ram4}, 32'hA4);
        run_op(1'b0, 1'b0, cyc);
        check("rdw_lat", cyc, 32'd3);
        check("rdw_hit", {31'd0, hit}, 32'd1);
        check("rdw_chit", {30'd0, cache_hit}, 32'd0);
        check("rdw_dout", {24'd0, data_out}, 32'h50);
        // Read with rw flipped high during LOOKUP: still a 3-cycle read hit
        run_op(1'b0, 1'b1, cyc);
        check("flip2_lat", cyc, 32'd3);
        check("flip2_dout", {24'd0, data_out}, 32'h51);
        check("flip2_chit", {30'd0, cache_hit}, 32'd1);
        for (int k = 2; k < 4; k++) begin
            run_op(1'b0, 1'b0, cyc);
            check($sformatf("rdw_dout%0d", k), {24'd0, data_out}, 32'h50 + k);
        end

        // Read miss on address 4, reset asserted while in FETCH
        @(negedge clk);
        check("abort_idle", {28'd0, state}, 32'd1);
        rw   = 1'b0;
        enab = 1'b1;
        @(posedge clk);
        #1;
        enab = 1'b0;
        check("abort_lookup", {28'd0, state}, 32'd2);
        @(posedge clk);
        #1;
        check("abort_fetch", {28'd0, state}, 32'd3);
        check("abort_enab", {31'd0, cache_enab}, 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("abort_state", {28'd0, state}, 32'd0);
        check("abort_cclr", {31'd0, cache_clr}, 32'd1);
        for (int k = 0; k < 8; k++)
            check($sformatf("abort_ram%0d", k), {24'd0, t_ram[k]}, 32'hA0 + k);
        check("abort_data0", {24'd0, data0}, 32'd0);
        check("abort_dout", {24'd0, data_out}, 32'd0);
        check("abort_i_out", {29'd0, i_out}, 32'd0);
        clr = 1'b0;
        run_op(1'b0, 1'b0, cyc);
        check("post_lat", cyc, 32'd4);
        check("post_dout", {24'd0, data_out}, 32'hA0);
        check("post_hit", {31'd0, hit}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
